md5_lane_collector: RTL and testbench

Multi-lane result collector for the MD5 nonce search. It sits between `LANES` parallel MD5 engine lanes and `tap_encoder`. It checks each returned digest for a run-time-selectable count of leading zero hex nibbles and tracks the lowest matching nonce. It reports that nonce only once every lane has covered all nonces below it, so out-of-order lane completion can never yield a wrong answer.

---
 rtl/md5_lane_collector_if.sv | 49 ++++
 rtl/md5_lane_collector.sv | 153 +++++++++++++++
 tb/tb_md5_lane_collector.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/md5_lane_collector_if.sv
// md5_lane_collector_if
//   Bundle between the MD5 lane engines / tap_encoder side (master) and the
//   lane result collector (slave).
//   zero_nibbles : required leading zero hex nibbles (static outside reset)
//   lane_valid   : one-cycle digest strobe per lane
//   lane_nonce   : nonce tag per lane, lane l at [l*NONCE_WIDTH +: NONCE_WIDTH]
//   lane_digest  : digest per lane, first hex character is the MSB nibble
//   halt         : dispatcher stop request
//   result_valid : level, high once the result is final
//   result_data  : winning nonce, zero-extended
//   seq_error    : sticky lane ordering violation (only with LANE_ORDER_CHECK_EN)
interface md5_lane_collector_if #(
    parameter int LANES            = 4,
    parameter int NONCE_WIDTH      = 24,
    parameter int DIGEST_WIDTH     = 128,
    parameter int RESULT_WIDTH     = 128,
    parameter int MAX_ZERO_NIBBLES = 8
);
    localparam int ZN_WIDTH = $clog2(MAX_ZERO_NIBBLES + 1);

    logic [ZN_WIDTH-1:0]             zero_nibbles;
    logic [LANES-1:0]                lane_valid;
    logic [LANES*NONCE_WIDTH-1:0]    lane_nonce;
    logic [LANES*DIGEST_WIDTH-1:0]   lane_digest;
    logic                            halt;
    logic                            result_valid;
    logic [RESULT_WIDTH-1:0]         result_data;
`ifdef LANE_ORDER_CHECK_EN
    logic                            seq_error;

    modport master (
        output zero_nibbles, lane_valid, lane_nonce, lane_digest,
        input  halt, result_valid, result_data, seq_error
    );
    modport slave (
        input  zero_nibbles, lane_valid, lane_nonce, lane_digest,
        output halt, result_valid, result_data, seq_error
    );
`else
    modport master (
        output zero_nibbles, lane_valid, lane_nonce, lane_digest,
        input  halt, result_valid, result_data
    );
    modport slave (
        input  zero_nibbles, lane_valid, lane_nonce, lane_digest,
        output halt, result_valid, result_data
    );
`endif
endinterface

// File: rtl/md5_lane_collector.sv
// md5_lane_collector
//   Collects digests from LANES round-robin MD5 lanes, finds the lowest nonce
//   whose digest has at least zero_nibbles leading zero nibbles, and reports it
//   only after every lane has delivered all nonces below it.
//   Ports: clk, reset (async, active-high), bus (md5_lane_collector_if.slave).
//   Optional feature macro: LANE_ORDER_CHECK_EN adds the per-lane nonce order
//   comparator and the sticky seq_error output.
module md5_lane_collector #(
    parameter int LANES            = 4,
    parameter int NONCE_WIDTH      = 24,
    parameter int DIGEST_WIDTH     = 128,
    parameter int RESULT_WIDTH     = 128,
    parameter int MAX_ZERO_NIBBLES = 8
) (
    input logic                 clk,
    input logic                 reset,
    md5_lane_collector_if.slave bus
);
    localparam int NE_WIDTH = NONCE_WIDTH + 1;

    typedef enum logic [1:0] {SEARCH, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [NONCE_WIDTH-1:0]  best_q, best_d;
    logic [NE_WIDTH-1:0]     next_expected_q [LANES];
    logic [NE_WIDTH-1:0]     next_expected_d [LANES];
    logic                    halt_q, halt_d;
    logic                    result_valid_q, result_valid_d;
    logic [RESULT_WIDTH-1:0] result_data_q, result_data_d;

    logic [LANES-1:0]        lane_match;
    logic                    any_match;
    logic [NONCE_WIDTH-1:0]  min_nonce;
    logic                    covered;

    // A lane matches when none of the first zero_nibbles nibbles is nonzero.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_match[l] = bus.lane_valid[l];
            for (int i = 0; i < MAX_ZERO_NIBBLES; i++) begin
                if (i < int'(bus.zero_nibbles) &&
                    bus.lane_digest[l*DIGEST_WIDTH + DIGEST_WIDTH - 1 - 4*i -: 4] != 4'h0)
                    lane_match[l] = 1'b0;
            end
        end
    end

    always_comb begin
        any_match = 1'b0;
        min_nonce = '1;
        for (int l = 0; l < LANES; l++) begin
            if (lane_match[l] &&
                (!any_match || bus.lane_nonce[l*NONCE_WIDTH +: NONCE_WIDTH] < min_nonce)) begin
                min_nonce = bus.lane_nonce[l*NONCE_WIDTH +: NONCE_WIDTH];
                any_match = 1'b1;
            end
        end
    end

    // Lane l has delivered every nonce below next_expected[l]; once all lanes
    // are past best, no smaller nonce can still be in flight.
    always_comb begin
        covered = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            if (next_expected_q[l] <= {1'b0, best_q})
                covered = 1'b0;
        end
    end

    always_comb begin
        state_d         = state_q;
        best_d          = best_q;
        next_expected_d = next_expected_q;
        result_valid_d  = result_valid_q;
        result_data_d   = result_data_q;

        if (state_q != DONE) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.lane_valid[l])
                    next_expected_d[l] = next_expected_q[l] + NE_WIDTH'(LANES);
            end
        end

        case (state_q)
            SEARCH: begin
                if (any_match) begin
                    best_d  = min_nonce;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (any_match && min_nonce < best_q)
                    best_d = min_nonce;
                if (covered) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_data_d  = RESULT_WIDTH'(best_d);
                end
            end
            default: ;
        endcase

        halt_d = (state_d != SEARCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= SEARCH;
            best_q         <= '1;
            halt_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            for (int l = 0; l < LANES; l++)
                next_expected_q[l] <= NE_WIDTH'(l);
        end else begin
            state_q         <= state_d;
            best_q          <= best_d;
            halt_q          <= halt_d;
            result_valid_q  <= result_valid_d;
            result_data_q   <= result_data_d;
            next_expected_q <= next_expected_d;
        end
    end

    assign bus.halt         = halt_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_data  = result_data_q;

`ifdef LANE_ORDER_CHECK_EN
    logic seq_error_q, seq_error_d;

    // Count still advances and the digest is still evaluated on a mismatch.
    always_comb begin
        seq_error_d = seq_error_q;
        if (state_q != DONE) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.lane_valid[l] &&
                    {1'b0, bus.lane_nonce[l*NONCE_WIDTH +: NONCE_WIDTH]} != next_expected_q[l])
                    seq_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            seq_error_q <= 1'b0;
        else
            seq_error_q <= seq_error_d;
    end

    assign bus.seq_error = seq_error_q;
`endif
endmodule

// File: tb/tb_md5_lane_collector.sv
module tb_md5_lane_collector;
    localparam int NN = 40;   // nonces offered per scenario

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md5_lane_collector_if bus ();
    md5_lane_collector dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [127:0] dig_tab [64];
    bit           match_tab [64];
    bit           seen [64];
    int           next_idx [4];
    int           m_state;     // 0 searching, 1 candidate held, 2 reported
    int           m_best;      // -1 = no candidate
    int           m_rd;
    int           cyc, halt_cyc, rv_cyc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        for (int l = 0; l < 4; l++) next_idx[l] = 0;
        m_state = 0; m_best = -1; m_rd = 0;
        cyc = 0; halt_cyc = -1; rv_cyc = -1;
    endtask

    task automatic clear_matches();
        for (int k = 0; k < 64; k++) match_tab[k] = 1'b0;
    endtask

    // Digests are random except for the leading nibbles that decide a match.
    task automatic make_digests(input int zn);
        logic [127:0] d;
        for (int n = 0; n < 64; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            if (zn == 0) match_tab[n] = 1'b1;
            if (match_tab[n]) begin
                for (int i = 0; i < zn; i++) d[127-4*i -: 4] = 4'h0;
            end else begin
                d[127-4*(zn-1) -: 4] = 4'($urandom_range(15, 1));
            end
            dig_tab[n] = d;
        end
    endtask

    task automatic start_scn(input int zn);
        @(negedge clk);
        reset = 1'b1;
        bus.zero_nibbles = 4'(zn);
        bus.lane_valid = '0;
        model_reset();
        #1 reset = 1'b0;
    endtask

    task automatic do_cycle(input logic [3:0] want);
        logic [3:0] v;
        int nn [4];
        int n, pre, mm;
        bit cov;
        @(negedge clk);
        v = '0;
        for (int l = 0; l < 4; l++) begin
            n = l + 4*next_idx[l];
            nn[l] = n;
            if (want[l] && n < NN) begin
                v[l] = 1'b1;
                bus.lane_nonce[l*24 +: 24]   = 24'(n);
                bus.lane_digest[l*128 +: 128] = dig_tab[n];
                next_idx[l]++;
            end
        end
        bus.lane_valid = v;
        // reference: report when every nonce below the candidate has been seen
        pre = m_state;
        cov = (pre == 1);
        if (cov) for (int k = 0; k < m_best; k++) if (!seen[k]) cov = 1'b0;
        if (pre != 2) begin
            mm = -1;
            for (int l = 0; l < 4; l++) begin
                if (v[l]) begin
                    seen[nn[l]] = 1'b1;
                    if (match_tab[nn[l]] && (mm < 0 || nn[l] < mm)) mm = nn[l];
                end
            end
            if (mm >= 0 && (m_best < 0 || mm < m_best)) m_best = mm;
            if (pre == 0 && mm >= 0) m_state = 1;
            if (pre == 1 && cov) begin m_state = 2; m_rd = m_best; end
        end
        @(posedge clk);
        #1;
        check("halt", 128'(bus.halt), 128'(m_state != 0));
        check("result_valid", 128'(bus.result_valid), 128'(m_state == 2));
        check("result_data", bus.result_data, 128'(m_rd));
        if (bus.halt && halt_cyc < 0) halt_cyc = cyc;
        if (bus.result_valid && rv_cyc < 0) rv_cyc = cyc;
        cyc++;
        bus.lane_valid = '0;
    endtask

    task automatic run(input int delay_lane, input int delay_until, input int prob, input int ncyc);
        logic [3:0] w;
        for (int c = 0; c < ncyc; c++) begin
            for (int l = 0; l < 4; l++)
                w[l] = !(l == delay_lane && c < delay_until) && ($urandom_range(99, 0) < prob);
            do_cycle(w);
        end
    endtask

    task automatic final_chk(input string tag, input int exp);
        check({tag, "_valid"}, 128'(bus.result_valid), 128'(1));
        check({tag, "_data"}, bus.result_data, 128'(exp));
    endtask

    initial begin
        int a, b;
        reset = 1'b1;
        bus.zero_nibbles = 4'd5;
        bus.lane_valid = '0;
        bus.lane_nonce = '0;
        bus.lane_digest = '0;
        #12;
        check("rst_halt", 128'(bus.halt), 128'(0));
        check("rst_result_valid", 128'(bus.result_valid), 128'(0));
        check("rst_result_data", bus.result_data, 128'(0));
`ifdef LANE_ORDER_CHECK_EN
        check("rst_seq_error", 128'(bus.seq_error), 128'(0));
`endif

        // single match at nonce 9, lanes in order
        clear_matches(); match_tab[9] = 1'b1; make_digests(5);
        start_scn(5);
        run(-1, 0, 100, 14);
        check("s1_halt_cycle", 128'(halt_cyc), 128'(2));
        check("s1_rv_cycle", 128'(rv_cyc), 128'(3));
        final_chk("s1", 9);
`ifdef LANE_ORDER_CHECK_EN
        check("s1_seq_error", 128'(bus.seq_error), 128'(0));
`endif

        // 10 reported first, lane 3 late with 7
        clear_matches(); match_tab[10] = 1'b1; match_tab[7] = 1'b1; make_digests(4);
        start_scn(4);
        run(3, 6, 100, 16);
        check("s2_halt_cycle", 128'(halt_cyc), 128'(2));
        final_chk("s2", 7);

        // 8 and 6 in the same cycle
        clear_matches(); match_tab[8] = 1'b1; match_tab[6] = 1'b1; make_digests(5);
        start_scn(5);
        run(2, 1, 100, 16);
        final_chk("s3", 6);

        // zero nibbles: everything matches
        clear_matches(); make_digests(0);
        start_scn(0);
        run(-1, 0, 60, 12);
        final_chk("s4", 0);

        // random matches, random schedule
        for (int r = 0; r < 3; r++) begin
            a = $urandom_range(39, 8); b = $urandom_range(39, 8);
            clear_matches(); match_tab[a] = 1'b1; match_tab[b] = 1'b1; make_digests(3);
            start_scn(3);
            run($urandom_range(3, 0), $urandom_range(6, 0), 55, 40);
            final_chk("s5", (a < b) ? a : b);
        end

        // no match at all stays searching
        clear_matches(); make_digests(6);
        start_scn(6);
        run(-1, 0, 70, 20);
        check("s6_halt", 128'(bus.halt), 128'(0));
        check("s6_result_valid", 128'(bus.result_valid), 128'(0));

        // reset mid-candidate, then rerun
        clear_matches(); match_tab[20] = 1'b1; make_digests(5);
        start_scn(5);
        run(-1, 0, 100, 6);
        check("s7_pre_halt", 128'(bus.halt), 128'(1));
        #1 reset = 1'b1;
        #1;
        check("s7_rst_halt", 128'(bus.halt), 128'(0));
        check("s7_rst_result_valid", 128'(bus.result_valid), 128'(0));
        check("s7_rst_result_data", bus.result_data, 128'(0));
        start_scn(5);
        run(-1, 0, 70, 24);
        final_chk("s7", 20);

`ifdef LANE_ORDER_CHECK_EN
        // lane 2 delivers nonce 6 before nonce 2
        clear_matches(); make_digests(5);
        start_scn(5);
        @(negedge clk);
        bus.lane_valid = 4'b0100;
        bus.lane_nonce[2*24 +: 24] = 24'd6;
        bus.lane_digest[2*128 +: 128] = dig_tab[6];
        @(posedge clk); #1;
        bus.lane_valid = '0;
        check("s8_seq_error", 128'(bus.seq_error), 128'(1));
        repeat (4) @(posedge clk);
        #1 check("s8_seq_sticky", 128'(bus.seq_error), 128'(1));
        reset = 1'b1;
        #1 check("s8_seq_cleared", 128'(bus.seq_error), 128'(0));
        reset = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
